// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed FIR sequencer.
// round_trunc works on a 128-bit sign-extended accumulator so callers of any width can share it.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  function automatic int acc_width(input int data_width, input int num_taps);
    return 2 * data_width + $clog2(num_taps);
  endfunction

  // Round half-up at bit q-1, then keep dw bits starting at bit q (wraps, no saturation).
  function automatic logic signed [127:0] round_trunc(input logic signed [127:0] acc,
                                                      input int q, input int dw);
    logic signed [127:0] shifted;
    logic [127:0] mask;
    shifted = (acc + (128'sd1 <<< (q - 1))) >>> q;
    mask = (128'd1 << dw) - 128'd1;
    return shifted & mask;
  endfunction

endpackage

// File: rtl/fir_mac_step.sv
// Registered signed multiply-accumulate; sum exposes acc + a*b so the final tap can be rounded
// in the same cycle it is computed.
module fir_mac_step #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 35
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + {{(ACC_WIDTH - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  always_ff @(posedge clk) begin
    if (clr)
      acc <= '0;
    else if (en)
      acc <= sum;
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one MAC walks the taps over NUM_TAPS cycles per sample, owning the
// delay line and a writable coefficient bank; results leave over a valid/ready handshake.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int Q_FORMAT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]  coef_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_wr_data,
  output logic                         coef_wr_ready,
  output logic                         busy
);

  localparam int AW    = $clog2(NUM_TAPS);
  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   TAPS   = (AW + 1)'(NUM_TAPS);

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] x    [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] coef [NUM_TAPS];
  logic [AW-1:0]                k;
  logic                         accept, last_tap, coef_we;
  logic signed [ACC_W-1:0]      mac_sum;
  logic signed [127:0]          sum_ext;

  assign accept   = (state == IDLE) && in_valid;
  assign last_tap = (state == ACCUM) && (k == K_LAST);
  assign coef_we  = coef_wr_en && (state == IDLE) && ({1'b0, coef_wr_addr} < TAPS);
  assign sum_ext  = {{(128 - ACC_W){mac_sum[ACC_W-1]}}, mac_sum};

  fir_mac_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_W)
  ) u_mac (
    .clk(clk),
    .clr(rst || accept),
    .en (state == ACCUM),
    .a  (coef[k]),
    .b  (x[k]),
    .sum(mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    coef_wr_ready = 1'b0;
    out_valid     = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready      = 1'b1;
        coef_wr_ready = 1'b1;
        if (in_valid)
          state_nxt = ACCUM;
      end
      ACCUM: begin
        if (k == K_LAST)
          state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficient writes land on the accept edge, so a same-cycle write is seen by the first tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= '0;
      end
      k        <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        x[0] <= in_data;
        for (int i = 1; i < NUM_TAPS; i++)
          x[i] <= x[i-1];
        k <= '0;
      end else if (state == ACCUM) begin
        k <= last_tap ? '0 : k + 1'b1;
      end
      if (last_tap)
        out_data <= DATA_WIDTH'(round_trunc(sum_ext, Q_FORMAT, DATA_WIDTH));
      if (coef_we)
        coef[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (4 taps, Q8) with a small reference model for the
// randomized tail; expectations for directed steps are hand-computed constants.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int NT = 4;
  localparam int QF = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 coef_wr_en = 1'b0;
  logic [1:0]           coef_wr_addr = '0;
  logic signed [DW-1:0] coef_wr_data = '0;
  logic                 coef_wr_ready;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  logic signed [DW-1:0] mCoef [NT];
  logic signed [DW-1:0] mX    [NT];
  logic [1:0]           pendAddr;
  logic signed [DW-1:0] pendData;
  logic                 leak;

  fir_mac_sequencer #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .Q_FORMAT(QF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_wr_ready(coef_wr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] modelOut();
    logic signed [127:0] acc;
    logic signed [127:0] prod;
    logic signed [127:0] r;
    acc = '0;
    for (int i = 0; i < NT; i++) begin
      prod = mCoef[i] * mX[i];
      acc  = acc + prod;
    end
    r = round_trunc(acc, QF, DW);
    return r[DW-1:0];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NT; i++) begin
      mCoef[i] = '0;
      mX[i]    = '0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  task automatic writeCoef(input logic [1:0] addr, input logic signed [DW-1:0] data);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = addr;
    coef_wr_data = data;
    mCoef[addr]  = data;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  // mode 0: plain; 1: coef write during first ACCUM cycle; 2: coef write with the sample;
  // 3: reset in the second ACCUM cycle (returns right after the reset edge).
  task automatic applyStimulus(input logic signed [DW-1:0] d, input int mode, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (mode == 2) begin
      coef_wr_en      = 1'b1;
      coef_wr_addr    = pendAddr;
      coef_wr_data    = pendData;
      mCoef[pendAddr] = pendData;
    end
    for (int i = NT - 1; i > 0; i--)
      mX[i] = mX[i-1];
    mX[0] = d;
    @(negedge clk);
    in_valid   = 1'b0;
    coef_wr_en = 1'b0;
    lat  = 0;
    leak = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0)
        leak = 1'b1;
      if (mode == 1 && lat == 0) begin
        coef_wr_en   = 1'b1;
        coef_wr_addr = pendAddr;
        coef_wr_data = pendData;
        checkOutput("coef_wr_ready_accum", {31'd0, coef_wr_ready}, 32'd0);
      end
      if (mode == 3 && lat == 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        return;
      end
      @(negedge clk);
      coef_wr_en = 1'b0;
      lat++;
    end
    if (out_valid === 1'b1 && in_ready !== 1'b0)
      leak = 1'b1;
  endtask

  task automatic completeTransfer(input string tag);
    @(negedge clk);
    checkOutput({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic sampleCheck(input logic signed [DW-1:0] d, input logic [DW-1:0] exp,
                             input string tag);
    int lat;
    applyStimulus(d, 0, lat);
    checkOutput({tag, "_latency"}, lat, 32'd4);
    checkOutput({tag, "_in_ready_low"}, {31'd0, leak}, 32'd0);
    checkOutput({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
    completeTransfer(tag);
  endtask

  initial begin
    int lat;
    clearModel();
    pendAddr = '0;
    pendData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_coef_wr_ready", {31'd0, coef_wr_ready}, 32'd1);

    // Step response with unity coefficients
    $display("[TB] step response");
    for (int i = 0; i < NT; i++)
      writeCoef(2'(i), 16'sh0100);
    sampleCheck(16'sh0100, 16'h0100, "step1");
    sampleCheck(16'sh0100, 16'h0200, "step2");
    sampleCheck(16'sh0100, 16'h0300, "step3");
    sampleCheck(16'sh0100, 16'h0400, "step4");

    // Backpressure: delay line becomes [0200,0100,0100,0100] -> 0x0500
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'sh0200, 0, lat);
    checkOutput("bp_latency", lat, 32'd4);
    checkOutput("bp_first_data", {16'd0, out_data}, 32'h0500);
    for (int c = 0; c < 6; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = 16'sh7000;
      @(negedge clk);
      checkOutput("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_out_data_hold", {16'd0, out_data}, 32'h0500);
      checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    completeTransfer("bp_release");
    @(negedge clk);
    checkOutput("bp_single_transfer", {31'd0, out_valid}, 32'd0);
    // Ignored pulses must not have shifted: [0000,0200,0100,0100] -> 0x0400
    sampleCheck(16'sh0000, 16'h0400, "bp_after");

    // Coef write gating
    $display("[TB] coefficient write gating");
    pendAddr = 2'd0;
    pendData = 16'sh0200;
    applyStimulus(16'sh0100, 1, lat);
    checkOutput("wr_drop_data", {16'd0, out_data}, 32'h0400);
    completeTransfer("wr_drop");
    applyStimulus(16'sh0100, 2, lat);
    checkOutput("wr_same_cycle_data", {16'd0, out_data}, 32'h0500);
    completeTransfer("wr_same_cycle");

    // Rounding, positive and negative
    $display("[TB] rounding");
    doReset();
    writeCoef(2'd0, 16'sh0080);
    sampleCheck(16'sh0001, 16'h0001, "round_pos");
    doReset();
    writeCoef(2'd0, 16'sh0080);
    sampleCheck(-16'sh0001, 16'h0000, "round_neg");

    // Reset in the middle of accumulation
    $display("[TB] reset mid-accumulation");
    doReset();
    for (int i = 0; i < NT; i++)
      writeCoef(2'(i), 16'sh0100);
    applyStimulus(16'sh0300, 3, lat);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < NT; i++)
      writeCoef(2'(i), 16'sh0100);
    sampleCheck(16'sh0100, 16'h0100, "midrst_after");

    // Wrap with full-scale coefficients and samples
    $display("[TB] wrap");
    doReset();
    for (int i = 0; i < NT; i++)
      writeCoef(2'(i), 16'sh7FFF);
    sampleCheck(16'sh7FFF, 16'hFF00, "wrap1");
    sampleCheck(16'sh7FFF, 16'hFE00, "wrap2");
    sampleCheck(16'sh7FFF, 16'hFD00, "wrap3");
    sampleCheck(16'sh7FFF, 16'hFC00, "wrap4");

    // Random samples and coefficients against the reference model
    $display("[TB] random");
    doReset();
    for (int n = 0; n < 1000; n++) begin
      int mode;
      if ($urandom_range(0, 1) == 1)
        writeCoef(2'($urandom_range(0, 3)), 16'($urandom));
      mode     = int'($urandom_range(0, 2));
      pendAddr = 2'($urandom_range(0, 3));
      pendData = 16'($urandom);
      applyStimulus(16'($urandom), mode, lat);
      checkOutput("rand_data", {16'd0, out_data}, {16'd0, modelOut()});
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
